// File: rtl/feistel8_pkg.sv
// Shared definitions for the 8-bit Feistel cipher: widths, DES S1 table,
// controller state encoding, and the expansion/permutation helpers.
// Optional build macro used elsewhere in this slice: FEISTEL8_ENC_MODE_EN.
package feistel8_pkg;

   localparam int HALF_W = 4;
   localparam int BLK_W  = 8;
   localparam int KEY_W  = 6;

   // DES S1, indexed [row][column]
   localparam logic [3:0] SBOX [4][16] = '{
      '{4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8, 4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7},
      '{4'h0, 4'hF, 4'h7, 4'h4, 4'hE, 4'h2, 4'hD, 4'h1, 4'hA, 4'h6, 4'hC, 4'hB, 4'h9, 4'h5, 4'h3, 4'h8},
      '{4'h4, 4'h1, 4'hE, 4'h8, 4'hD, 4'h6, 4'h2, 4'hB, 4'hF, 4'hC, 4'h9, 4'h7, 4'h3, 4'hA, 4'h5, 4'h0},
      '{4'hF, 4'hC, 4'h8, 4'h2, 4'h4, 4'h9, 4'h1, 4'h7, 4'h5, 4'hB, 4'h3, 4'hE, 4'hA, 4'h0, 4'h6, 4'hD}
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 4 -> 6 bit expansion: wrap the end bits around the half
   function automatic logic [KEY_W-1:0] expand(input logic [HALF_W-1:0] x);
      return {x[0], x, x[3]};
   endfunction

   // Output bit shuffle applied to the S-box result
   function automatic logic [HALF_W-1:0] perm(input logic [HALF_W-1:0] s);
      return {s[1], s[3], s[0], s[2]};
   endfunction

endpackage

// File: rtl/feistel8_dec_iter_if.sv
// Handshake bundle for feistel8_dec_iter: ciphertext/key input channel and
// plaintext output channel, both valid/ready.
// With FEISTEL8_ENC_MODE_EN defined the bundle also carries the enc select.
interface feistel8_dec_iter_if
   import feistel8_pkg::*;
#(
   parameter int ROUNDS = 2
);

   logic                    in_valid;
   logic                    in_ready;
   logic [BLK_W-1:0]        in_data;
   logic [KEY_W*ROUNDS-1:0] in_keys;
   logic                    out_valid;
   logic                    out_ready;
   logic [BLK_W-1:0]        out_data;
`ifdef FEISTEL8_ENC_MODE_EN
   logic                    enc;
`endif

`ifdef FEISTEL8_ENC_MODE_EN
   modport master (
      output in_valid, in_data, in_keys, out_ready, enc,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, in_keys, out_ready, enc,
      output in_ready, out_valid, out_data
   );
`else
   modport master (
      output in_valid, in_data, in_keys, out_ready,
      input  in_ready, out_valid, out_data
   );
   modport slave (
      input  in_valid, in_data, in_keys, out_ready,
      output in_ready, out_valid, out_data
   );
`endif

endinterface

// File: rtl/feistel8_f.sv
// Combinational Feistel round function F(x, k): expand, key mix, S1 lookup,
// permute. Shared by every round of the iterative core.
module feistel8_f
   import feistel8_pkg::*;
(
   input  logic [HALF_W-1:0] x,
   input  logic [KEY_W-1:0]  k,
   output logic [HALF_W-1:0] f
);

   logic [KEY_W-1:0]  y;
   logic [HALF_W-1:0] s;

   // Outer bits of the mixed value select the row, inner four the column
   always_comb begin
      y = expand(x) ^ k;
      s = SBOX[{y[5], y[0]}][y[4:1]];
      f = perm(s);
   end

endmodule

// File: rtl/feistel8_dec_iter.sv
// Iterative 8-bit Feistel decryptor, one round per clock, keys applied from
// k[ROUNDS-1] down to k[0]. Valid/ready on both sides, result held in DONE
// until the consumer takes it.
// Build option FEISTEL8_ENC_MODE_EN: adds bus.enc; when set at accept, the
// block runs forward rounds with keys k[0]..k[ROUNDS-1] under the same timing.
//
//  state | meaning
//  ------+----------------------------------------------------------
//  IDLE  | waiting for a block, in_ready=1
//  RUN   | one round per edge, rnd counts ROUNDS-1 down to 0
//  DONE  | plaintext on out_data, out_valid=1 until out_ready
module feistel8_dec_iter
   import feistel8_pkg::*;
#(
   parameter int ROUNDS = 2
) (
   input logic               clk,
   input logic               rst,
   feistel8_dec_iter_if.slave bus
);

   localparam int RND_W  = $clog2(ROUNDS) + 1;
   localparam int KBUS_W = KEY_W * ROUNDS;

   state_t            state;
   logic [BLK_W-1:0]  dreg;
   logic [KBUS_W-1:0] kreg;
   logic [RND_W-1:0]  rnd;
   logic              in_ready_q;
   logic              out_valid_q;
`ifdef FEISTEL8_ENC_MODE_EN
   logic              enc_q;
`endif

   logic [RND_W-1:0]  kidx;
   logic [KBUS_W-1:0] kshift;
   logic [KEY_W-1:0]  rkey;
   logic [HALF_W-1:0] f_in;
   logic [HALF_W-1:0] f_out;
   logic [BLK_W-1:0]  nxt;

   // Pick this round's key and the half that feeds F
   always_comb begin
      kidx = rnd;
      f_in = dreg[BLK_W-1:HALF_W];
`ifdef FEISTEL8_ENC_MODE_EN
      if (enc_q) begin
         kidx = RND_W'(ROUNDS - 1) - rnd;
         f_in = dreg[HALF_W-1:0];
      end
`endif
      kshift = kreg >> (KEY_W * int'(kidx));
      rkey   = kshift[KEY_W-1:0];
   end

   feistel8_f u_f (
      .x (f_in),
      .k (rkey),
      .f (f_out)
   );

   // Inverse round by default; forward round when encrypting
   always_comb begin
      nxt = {dreg[HALF_W-1:0] ^ f_out, dreg[BLK_W-1:HALF_W]};
`ifdef FEISTEL8_ENC_MODE_EN
      if (enc_q) begin
         nxt = {dreg[HALF_W-1:0], dreg[BLK_W-1:HALF_W] ^ f_out};
      end
`endif
   end

   // Controller and datapath registers; handshake outputs are flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         dreg        <= '0;
         kreg        <= '0;
         rnd         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef FEISTEL8_ENC_MODE_EN
         enc_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  dreg       <= bus.in_data;
                  kreg       <= bus.in_keys;
                  rnd        <= RND_W'(ROUNDS - 1);
`ifdef FEISTEL8_ENC_MODE_EN
                  enc_q      <= bus.enc;
`endif
                  in_ready_q <= 1'b0;
                  state      <= RUN;
               end
            end
            RUN: begin
               dreg <= nxt;
               if (rnd == '0) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end else begin
                  rnd <= rnd - RND_W'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = dreg;

endmodule

// File: tb/tb_feistel8_dec_iter.sv
// Scoreboard bench for feistel8_dec_iter with a 1-round and a 2-round
// instance. Expected plaintext comes from a forward-cipher model: either the
// random plaintext that was encrypted, or a brute-force inversion over all
// 256 blocks. Covers FEISTEL8_ENC_MODE_EN when that macro is defined.
module tb_feistel8_dec_iter;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   feistel8_dec_iter_if #(.ROUNDS(1)) if1 ();
   feistel8_dec_iter_if #(.ROUNDS(2)) if2 ();

   feistel8_dec_iter #(.ROUNDS(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
   feistel8_dec_iter #(.ROUNDS(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

   typedef struct {
      logic [7:0] d;
      int         acc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   int sbox_t [64] = '{
      14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13
   };

   // ---------------- reference model ----------------
   function automatic int fmodel(input int x, input int k);
      int e, y, row, col, s;
      e   = ((x & 1) << 5) | ((x & 15) << 1) | ((x >> 3) & 1);
      y   = e ^ k;
      row = ((y >> 5) & 1) * 2 + (y & 1);
      col = (y >> 1) & 15;
      s   = sbox_t[row * 16 + col];
      return (((s >> 1) & 1) << 3) | (((s >> 3) & 1) << 2) | ((s & 1) << 1) | ((s >> 2) & 1);
   endfunction

   function automatic logic [7:0] enc_model(input logic [7:0] p, input logic [11:0] kb, input int rounds);
      int h, l, t;
      h = int'(p) >> 4;
      l = int'(p) & 15;
      for (int i = 0; i < rounds; i++) begin
         t = h ^ fmodel(l, (int'(kb) >> (6 * i)) & 63);
         h = l;
         l = t;
      end
      return 8'((h << 4) | l);
   endfunction

   function automatic logic [7:0] dec_model(input logic [7:0] c, input logic [11:0] kb, input int rounds);
      logic [7:0] r;
      r = 8'h00;
      for (int p = 0; p < 256; p++)
         if (enc_model(8'(p), kb, rounds) == c) r = 8'(p);
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_in(input int sel, input logic v, input logic [7:0] d, input logic [11:0] k);
      if (sel == 1) begin
         if1.in_valid = v;
         if1.in_data  = d;
         if1.in_keys  = k[5:0];
      end else begin
         if2.in_valid = v;
         if2.in_data  = d;
         if2.in_keys  = k;
      end
   endtask

   function automatic logic get_ready(input int sel);
      return (sel == 1) ? if1.in_ready : if2.in_ready;
   endfunction

   function automatic int qsize(input int sel);
      return (sel == 1) ? q1.size() : q2.size();
   endfunction

   // Called at a negedge; returns at the negedge after the accept edge,
   // with the inputs already scrambled.
   task automatic send(input int sel, input logic [7:0] c, input logic [11:0] k, input logic [7:0] expd);
      exp_t e;
      bit   done;
      done = 0;
      set_in(sel, 1'b1, c, k);
      for (int t = 0; t < 100 && !done; t++) begin
         if (get_ready(sel) === 1'b1) begin
            e.d   = expd;
            e.acc = cyc + 1;
            if (sel == 1) q1.push_back(e);
            else          q2.push_back(e);
            done = 1;
         end
         @(negedge clk);
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
      set_in(sel, 1'b0, 8'($urandom), 12'($urandom));
   endtask

   task automatic wait_drain(input int sel);
      for (int t = 0; t < 200 && qsize(sel) != 0; t++) @(negedge clk);
      if (qsize(sel) != 0) chk("drain_timeout", 32'(qsize(sel)), 32'd0);
   endtask

   task automatic mon(input int sel, input logic [7:0] d);
      exp_t e;
      int   lat;
      if (qsize(sel) == 0) begin
         chk("unexpected_output", 32'(d), 32'hFFFF_FFFF);
      end else begin
         if (sel == 1) begin e = q1.pop_front(); lat = 1; end
         else          begin e = q2.pop_front(); lat = 2; end
         chk((sel == 1) ? "latency_r1" : "latency_r2", 32'(cyc - e.acc), 32'(lat));
         chk((sel == 1) ? "data_r1" : "data_r2", 32'(d), 32'(e.d));
      end
   endtask

   // ---------------- monitors ----------------
   logic prev1 = 1'b0;
   logic prev2 = 1'b0;

   always @(negedge clk) begin
      if (if1.out_valid === 1'b1 && prev1 !== 1'b1) mon(1, if1.out_data);
      prev1 = if1.out_valid;
   end

   always @(negedge clk) begin
      if (if2.out_valid === 1'b1 && prev2 !== 1'b1) mon(2, if2.out_data);
      prev2 = if2.out_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0]  p, c;
      logic [11:0] k;

      rst = 1'b1;
      set_in(1, 1'b0, 8'h00, 12'h000);
      set_in(2, 1'b0, 8'h00, 12'h000);
      if1.out_ready = 1'b1;
      if2.out_ready = 1'b1;
`ifdef FEISTEL8_ENC_MODE_EN
      if1.enc = 1'b0;
      if2.enc = 1'b0;
`endif
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      chk("rst_in_ready_r1",  32'(if1.in_ready),  32'd1);
      chk("rst_out_valid_r1", 32'(if1.out_valid), 32'd0);
      chk("rst_out_data_r1",  32'(if1.out_data),  32'h00);
      chk("rst_in_ready_r2",  32'(if2.in_ready),  32'd1);
      chk("rst_out_valid_r2", 32'(if2.out_valid), 32'd0);
      chk("rst_out_data_r2",  32'(if2.out_data),  32'h00);

      // directed single-round vectors
      send(1, 8'hB0, 12'h032, dec_model(8'hB0, 12'h032, 1));
      wait_drain(1);
      send(1, 8'h00, 12'h000, 8'hD0);
      wait_drain(1);

      // random single-round blocks
      for (int i = 0; i < 32; i++) begin
         p = 8'($urandom);
         k = 12'($urandom_range(0, 63));
         send(1, enc_model(p, k, 1), k, p);
         wait_drain(1);
      end

      // random two-round blocks, back to back or with small gaps
      for (int i = 0; i < 256; i++) begin
         p = 8'($urandom);
         k = 12'($urandom);
         send(2, enc_model(p, k, 2), k, p);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      wait_drain(2);

      // back-pressure: hold the result in DONE and poke in_valid
      if1.out_ready = 1'b0;
      p = 8'h5A;
      k = 12'h02D;
      send(1, enc_model(p, k, 1), k, p);
      for (int t = 0; t < 20 && if1.out_valid !== 1'b1; t++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         chk("bp_out_valid", 32'(if1.out_valid), 32'd1);
         chk("bp_in_ready",  32'(if1.in_ready),  32'd0);
         chk("bp_out_data",  32'(if1.out_data),  32'(p));
         set_in(1, 1'(i % 2), 8'($urandom), 12'($urandom));
         @(negedge clk);
      end
      set_in(1, 1'b0, 8'h00, 12'h000);
      if1.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_out_valid", 32'(if1.out_valid), 32'd0);
      chk("bp_release_in_ready",  32'(if1.in_ready),  32'd1);
      repeat (3) @(negedge clk);
      chk("bp_no_extra_accept", 32'(q1.size()), 32'd0);

`ifdef FEISTEL8_ENC_MODE_EN
      // forward mode on the single-round instance
      if1.enc = 1'b1;
      send(1, 8'hBB, 12'h032, enc_model(8'hBB, 12'h032, 1));
      if1.enc = 1'b0;
      wait_drain(1);
      p = 8'($urandom);
      k = 12'($urandom);
      if2.enc = 1'b1;
      send(2, p, k, enc_model(p, k, 2));
      if2.enc = 1'b0;
      wait_drain(2);
      p = 8'($urandom);
      k = 12'($urandom);
      send(2, enc_model(p, k, 2), k, p);
      wait_drain(2);
`endif

      // reset in the middle of RUN drops the block
      p = 8'($urandom);
      k = 12'($urandom);
      send(2, enc_model(p, k, 2), k, p);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      q2.delete();
      chk("midrst_in_ready",  32'(if2.in_ready),  32'd1);
      chk("midrst_out_valid", 32'(if2.out_valid), 32'd0);
      chk("midrst_out_data",  32'(if2.out_data),  32'h00);
      repeat (4) @(negedge clk);
      chk("midrst_stays_idle", 32'(if2.out_valid), 32'd0);

      for (int i = 0; i < 4; i++) begin
         p = 8'($urandom);
         k = 12'($urandom);
         send(2, enc_model(p, k, 2), k, p);
      end
      wait_drain(2);

      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
